// File: rtl/axi_rw_bridge.sv
// Bridges a simple one-shot read/write request port onto single-beat AXI4 transactions.
// Handles byte-lane alignment for writes and read data, and reports non-OKAY responses.
module axi_rw_bridge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rw_cen_i,
   input  logic        rw_wen_i,
   input  logic [63:0] rw_addr_i,
   input  logic [63:0] rw_wdata_i,
   input  logic [2:0]  rw_size_i,
   output logic        rw_ready_o,
   output logic [63:0] rw_rdata_o,
   output logic        rw_err_o,
   output logic        aw_valid_o,
   input  logic        aw_ready_i,
   output logic [31:0] aw_addr_o,
   output logic [2:0]  aw_size_o,
   output logic [7:0]  aw_len_o,
   output logic [1:0]  aw_burst_o,
   output logic        w_valid_o,
   input  logic        w_ready_i,
   output logic [63:0] w_data_o,
   output logic [7:0]  w_strb_o,
   output logic        w_last_o,
   input  logic        b_valid_i,
   output logic        b_ready_o,
   input  logic [1:0]  b_resp_i,
   output logic        ar_valid_o,
   input  logic        ar_ready_i,
   output logic [31:0] ar_addr_o,
   output logic [2:0]  ar_size_o,
   output logic [7:0]  ar_len_o,
   output logic [1:0]  ar_burst_o,
   input  logic        r_valid_i,
   output logic        r_ready_o,
   input  logic [63:0] r_data_i,
   input  logic [1:0]  r_resp_i,
   input  logic        r_last_i
);

   // state   | meaning
   // IDLE    | waiting for rw_cen_i, captures the request
   // RD_ADDR | AR valid, waiting for ar_ready_i
   // RD_DATA | R ready, waiting for r_valid_i
   // WR_REQ  | AW and W valid, each dropped after its own handshake
   // WR_RESP | B ready, waiting for b_valid_i
   // DONE    | one-cycle rw_ready_o pulse, then back to IDLE
   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
   } state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic [63:0] w_data_q;
   logic [7:0]  w_strb_q;
   logic [63:0] rw_rdata_q;
   logic        aw_valid_q;
   logic        w_valid_q;
   logic        b_ready_q;
   logic        ar_valid_q;
   logic        r_ready_q;
   logic        rw_ready_q;
   logic        rw_err_q;

   logic [2:0]  size_clamp;
   logic [2:0]  off_in;
   logic [7:0]  strb_base;
   logic [63:0] wdata_aligned;
   logic [7:0]  strb_aligned;
   logic [63:0] rdata_aligned;
   logic        aw_pending;
   logic        w_pending;

   always_comb begin
      size_clamp = rw_size_i[2] ? 3'd3 : rw_size_i;
      off_in     = rw_addr_i[2:0];
      case (size_clamp[1:0])
         2'd0:    strb_base = 8'h01;
         2'd1:    strb_base = 8'h03;
         2'd2:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
      wdata_aligned = rw_wdata_i << {off_in, 3'b000};
      strb_aligned  = strb_base << off_in;
      rdata_aligned = r_data_i >> {addr_q[2:0], 3'b000};
      // a channel is still owed a handshake if it stays valid past this edge
      aw_pending    = aw_valid_q & ~aw_ready_i;
      w_pending     = w_valid_q & ~w_ready_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         rw_rdata_q <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         rw_ready_q <= 1'b0;
         rw_err_q   <= 1'b0;
      end else begin
         rw_ready_q <= 1'b0;
         rw_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rw_cen_i) begin
                  addr_q <= rw_addr_i[31:0];
                  size_q <= size_clamp;
                  if (rw_wen_i) begin
                     w_data_q   <= wdata_aligned;
                     w_strb_q   <= strb_aligned;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= WR_REQ;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (ar_ready_i) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_valid_i) begin
                  r_ready_q  <= 1'b0;
                  rw_rdata_q <= rdata_aligned;
                  rw_ready_q <= 1'b1;
                  rw_err_q   <= (r_resp_i != 2'b00);
                  state_q    <= DONE;
               end
            end
            WR_REQ: begin
               if (aw_ready_i) aw_valid_q <= 1'b0;
               if (w_ready_i)  w_valid_q  <= 1'b0;
               if (!aw_pending && !w_pending) begin
                  b_ready_q <= 1'b1;
                  state_q   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_valid_i) begin
                  b_ready_q  <= 1'b0;
                  rw_ready_q <= 1'b1;
                  rw_err_q   <= (b_resp_i != 2'b00);
                  state_q    <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rw_ready_o = rw_ready_q;
   assign rw_err_o   = rw_err_q;
   assign rw_rdata_o = rw_rdata_q;
   assign aw_valid_o = aw_valid_q;
   assign aw_addr_o  = addr_q;
   assign aw_size_o  = size_q;
   assign aw_len_o   = 8'd0;
   assign aw_burst_o = 2'b01;
   assign w_valid_o  = w_valid_q;
   assign w_data_o   = w_data_q;
   assign w_strb_o   = w_strb_q;
   assign w_last_o   = 1'b1;
   assign b_ready_o  = b_ready_q;
   assign ar_valid_o = ar_valid_q;
   assign ar_addr_o  = addr_q;
   assign ar_size_o  = size_q;
   assign ar_len_o   = 8'd0;
   assign ar_burst_o = 2'b01;
   assign r_ready_o  = r_ready_q;

   // single-beat reads never look at r_last; only the low address word reaches AXI
   logic unused_inputs;
   assign unused_inputs = ^{r_last_i, rw_addr_i[63:32]};

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Bench for axi_rw_bridge: directed corner cases plus random reads/writes against
// an expected-timeline model with a randomly stalling AXI slave.
module tb_axi_rw_bridge;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        rw_cen_i, rw_wen_i;
   logic [63:0] rw_addr_i, rw_wdata_i;
   logic [2:0]  rw_size_i;
   logic        rw_ready_o, rw_err_o;
   logic [63:0] rw_rdata_o;
   logic        aw_valid_o, aw_ready_i;
   logic [31:0] aw_addr_o;
   logic [2:0]  aw_size_o;
   logic [7:0]  aw_len_o;
   logic [1:0]  aw_burst_o;
   logic        w_valid_o, w_ready_i, w_last_o;
   logic [63:0] w_data_o;
   logic [7:0]  w_strb_o;
   logic        b_valid_i, b_ready_o;
   logic [1:0]  b_resp_i;
   logic        ar_valid_o, ar_ready_i;
   logic [31:0] ar_addr_o;
   logic [2:0]  ar_size_o;
   logic [7:0]  ar_len_o;
   logic [1:0]  ar_burst_o;
   logic        r_valid_i, r_ready_o, r_last_i;
   logic [63:0] r_data_i;
   logic [1:0]  r_resp_i;

   int          n_checks = 0;
   int          n_err = 0;
   logic [63:0] last_rd;

   axi_rw_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .rw_cen_i(rw_cen_i), .rw_wen_i(rw_wen_i), .rw_addr_i(rw_addr_i),
      .rw_wdata_i(rw_wdata_i), .rw_size_i(rw_size_i),
      .rw_ready_o(rw_ready_o), .rw_rdata_o(rw_rdata_o), .rw_err_o(rw_err_o),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
      .aw_size_o(aw_size_o), .aw_len_o(aw_len_o), .aw_burst_o(aw_burst_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
      .w_strb_o(w_strb_o), .w_last_o(w_last_o),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
      .ar_size_o(ar_size_o), .ar_len_o(ar_len_o), .ar_burst_o(ar_burst_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
      .r_resp_i(r_resp_i), .r_last_i(r_last_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_state();
      check_eq("rst rw_ready", rw_ready_o, 0);
      check_eq("rst rw_err", rw_err_o, 0);
      check_eq("rst rw_rdata", rw_rdata_o, 0);
      check_eq("rst ar_valid", ar_valid_o, 0);
      check_eq("rst r_ready", r_ready_o, 0);
      check_eq("rst aw_valid", aw_valid_o, 0);
      check_eq("rst w_valid", w_valid_o, 0);
      check_eq("rst b_ready", b_ready_o, 0);
      check_eq("rst aw_addr", aw_addr_o, 0);
      check_eq("rst ar_addr", ar_addr_o, 0);
      check_eq("rst w_data", w_data_o, 0);
      check_eq("rst w_strb", w_strb_o, 0);
   endtask

   task automatic scramble_req();
      rw_addr_i  = {$urandom, $urandom};
      rw_wdata_i = {$urandom, $urandom};
      rw_size_i  = 3'($urandom);
      rw_wen_i   = 1'($urandom);
   endtask

   // Timeline t counts negedges after the one where the request is driven.
   task automatic do_read(input logic [63:0] addr, input logic [2:0] sz, input logic [63:0] rd,
                          input logic [1:0] resp, input int ar_dly, input int r_dly, input bit hold);
      logic [63:0] exp_rd;
      int off, csz, t_exp, ar_w, r_w;
      off = int'(addr[2:0]);
      csz = (sz > 3) ? 3 : int'(sz);
      exp_rd = rd >> (8 * off);
      t_exp = 3 + ar_dly + r_dly;
      ar_w = 0;
      r_w = 0;
      @(negedge clk);
      rw_cen_i = 1'b1; rw_wen_i = 1'b0; rw_addr_i = addr; rw_size_i = sz;
      rw_wdata_i = {$urandom, $urandom};
      for (int t = 1; t <= t_exp; t++) begin
         @(negedge clk);
         check_eq("rd ar_valid", ar_valid_o, t <= 1 + ar_dly);
         check_eq("rd r_ready", r_ready_o, (t >= 2 + ar_dly) && (t <= 2 + ar_dly + r_dly));
         check_eq("rd aw_valid", aw_valid_o, 0);
         check_eq("rd rw_ready", rw_ready_o, t == t_exp);
         if (ar_valid_o) begin
            check_eq("rd ar_addr", ar_addr_o, addr[31:0]);
            check_eq("rd ar_size", ar_size_o, csz);
            check_eq("rd ar_len", ar_len_o, 0);
            check_eq("rd ar_burst", ar_burst_o, 1);
         end
         if (t == t_exp) begin
            check_eq("rd rdata", rw_rdata_o, exp_rd);
            check_eq("rd err", rw_err_o, resp != 2'b00);
            last_rd = exp_rd;
         end
         ar_ready_i = ar_valid_o && (ar_w >= ar_dly);
         if (ar_valid_o) ar_w++;
         r_valid_i = r_ready_o && (r_w >= r_dly);
         r_data_i  = r_valid_i ? rd : {$urandom, $urandom};
         r_resp_i  = r_valid_i ? resp : 2'($urandom);
         if (r_ready_o) r_w++;
         if (t == t_exp && !hold) rw_cen_i = 1'b0;
         else scramble_req();
      end
      ar_ready_i = 1'b0;
      r_valid_i = 1'b0;
      if (!hold) begin
         @(negedge clk);
         check_eq("rd pulse width", rw_ready_o, 0);
         check_eq("rd rdata hold", rw_rdata_o, last_rd);
      end
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [2:0] sz, input logic [63:0] wd,
                           input logic [1:0] resp, input int aw_dly, input int w_dly,
                           input int b_dly, input bit hold);
      logic [63:0] exp_data;
      logic [7:0]  exp_strb;
      int off, csz, m, t_exp, aw_w, w_w, b_w, mask;
      off = int'(addr[2:0]);
      csz = (sz > 3) ? 3 : int'(sz);
      mask = (1 << (1 << csz)) - 1;
      exp_strb = 8'((mask << off) & 255);
      exp_data = wd << (8 * off);
      m = (aw_dly > w_dly) ? aw_dly : w_dly;
      t_exp = 3 + m + b_dly;
      aw_w = 0; w_w = 0; b_w = 0;
      @(negedge clk);
      rw_cen_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = addr; rw_size_i = sz; rw_wdata_i = wd;
      for (int t = 1; t <= t_exp; t++) begin
         @(negedge clk);
         check_eq("wr aw_valid", aw_valid_o, t <= 1 + aw_dly);
         check_eq("wr w_valid", w_valid_o, t <= 1 + w_dly);
         check_eq("wr b_ready", b_ready_o, (t >= 2 + m) && (t <= 2 + m + b_dly));
         check_eq("wr ar_valid", ar_valid_o, 0);
         check_eq("wr rw_ready", rw_ready_o, t == t_exp);
         if (aw_valid_o) begin
            check_eq("wr aw_addr", aw_addr_o, addr[31:0]);
            check_eq("wr aw_size", aw_size_o, csz);
            check_eq("wr aw_len", aw_len_o, 0);
            check_eq("wr aw_burst", aw_burst_o, 1);
         end
         if (w_valid_o) begin
            check_eq("wr w_data", w_data_o, exp_data);
            check_eq("wr w_strb", w_strb_o, exp_strb);
            check_eq("wr w_last", w_last_o, 1);
         end
         if (t == t_exp) begin
            check_eq("wr err", rw_err_o, resp != 2'b00);
            check_eq("wr rdata untouched", rw_rdata_o, last_rd);
         end
         aw_ready_i = aw_valid_o && (aw_w >= aw_dly);
         if (aw_valid_o) aw_w++;
         w_ready_i = w_valid_o && (w_w >= w_dly);
         if (w_valid_o) w_w++;
         b_valid_i = b_ready_o && (b_w >= b_dly);
         b_resp_i  = b_valid_i ? resp : 2'($urandom);
         if (b_ready_o) b_w++;
         if (t == t_exp && !hold) rw_cen_i = 1'b0;
         else scramble_req();
      end
      aw_ready_i = 1'b0;
      w_ready_i = 1'b0;
      b_valid_i = 1'b0;
      if (!hold) begin
         @(negedge clk);
         check_eq("wr pulse width", rw_ready_o, 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      rw_cen_i = 0; rw_wen_i = 0; rw_addr_i = 0; rw_wdata_i = 0; rw_size_i = 0;
      aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
      ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 1;
      last_rd = 0;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst_n = 1'b1;

      do_read(64'h0000_0000_8000_0004, 3'd2, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
      check_eq("read example rdata", rw_rdata_o, 64'h0000_0000_1122_3344);
      do_write(64'h0000_0000_8000_0003, 3'd0, 64'h0000_0000_0000_00AB, 2'b00, 0, 0, 0, 0);
      do_write(64'h0000_0000_8000_0010, 3'd3, 64'hDEAD_BEEF_0123_4567, 2'b00, 3, 0, 0, 0);
      do_write(64'h0000_0000_8000_0020, 3'd1, 64'h0000_0000_0000_5A5A, 2'b00, 0, 2, 1, 0);
      do_read(64'h0000_0000_4000_0001, 3'd3, 64'hCAFE_F00D_1234_5678, 2'b10, 0, 5, 0);
      do_write(64'h0000_0000_0000_0105, 3'd6, 64'hFFEE_DDCC_BBAA_9988, 2'b11, 1, 1, 2, 0);

      // reset while the read sits in RD_DATA
      @(negedge clk);
      rw_cen_i = 1'b1; rw_wen_i = 1'b0; rw_addr_i = 64'h1000; rw_size_i = 3'd3;
      @(negedge clk);
      check_eq("abort ar_valid", ar_valid_o, 1);
      ar_ready_i = 1'b1;
      @(negedge clk);
      check_eq("abort r_ready", r_ready_o, 1);
      ar_ready_i = 1'b0; r_valid_i = 1'b0;
      rst_n = 1'b0; rw_cen_i = 1'b0;
      @(negedge clk);
      check_reset_state();
      rst_n = 1'b1;
      last_rd = 0;
      repeat (4) begin
         @(negedge clk);
         check_eq("abort no pulse", rw_ready_o, 0);
      end
      do_write(64'h0000_0000_2000_0006, 3'd1, 64'h0000_0000_0000_BEEF, 2'b00, 0, 0, 0, 0);

      // request held high across the pulse, second one starts from IDLE
      do_read(64'h0000_0000_3000_0002, 3'd2, 64'h0102_0304_0506_0708, 2'b00, 1, 1, 1);
      do_write(64'h0000_0000_3000_0007, 3'd0, 64'h0000_0000_0000_0077, 2'b00, 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [63:0] a, d;
         logic [2:0]  s;
         logic [1:0]  rsp;
         a = {$urandom, $urandom};
         d = {$urandom, $urandom};
         s = 3'($urandom);
         rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 1) == 1)
            do_write(a, s, d, rsp, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         else
            do_read(a, s, d, rsp, $urandom_range(0, 3), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)));
      end
      rw_cen_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/axi_rw_bridge.md
AXI_RW_BRIDGE -- requirements
Module: axi_rw_bridge

Interface
REQ-001 SHALL have ports, clock and reset first, one per line: name, direction, width, meaning.
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rw_cen_i  in  1  request, held by the requester until rw_ready_o
- rw_wen_i  in  1  1 = write, 0 = read
- rw_addr_i  in  64  byte address; only [31:0] forwarded
- rw_wdata_i  in  64  write data, LSB-aligned
- rw_size_i  in  3  0 = byte, 1 = half, 2 = word, 3 = dword; 4-7 treated as 3
- rw_ready_o  out  1  one-cycle completion pulse
- rw_rdata_o  out  64  read data, LSB-aligned
- rw_err_o  out  1  pulse with rw_ready_o when resp != OKAY
- AW channel: aw_valid_o 1, aw_ready_i 1, aw_addr_o 32, aw_size_o 3, aw_len_o 8, aw_burst_o 2
- W channel: w_valid_o 1, w_ready_i 1, w_data_o 64, w_strb_o 8, w_last_o 1
- B channel: b_valid_i 1, b_ready_o 1, b_resp_i 2
- AR channel: ar_valid_o 1, ar_ready_i 1, ar_addr_o 32, ar_size_o 3, ar_len_o 8, ar_burst_o 2
- R channel: r_valid_i 1, r_ready_o 1, r_data_i 64, r_resp_i 2, r_last_i 1

REQ-002 SHALL have no parameters; the data bus is 64 bits and the address bus is 32 bits.

Function
REQ-003 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and DONE.
REQ-004 SHALL capture addr, size, wen and wdata into registers in the IDLE cycle where rw_cen_i=1. The next state SHALL be RD_ADDR when wen=0 and WR_REQ when wen=1.
REQ-005 SHALL drive ar_valid_o=1 throughout RD_ADDR. On ar_ready_i it SHALL deassert ar_valid_o and move to RD_DATA.
REQ-006 SHALL drive r_ready_o=1 throughout RD_DATA. On r_valid_i it SHALL latch the read data and resp, then move to DONE.
REQ-007 SHALL assert aw_valid_o and w_valid_o together on entry to WR_REQ. Each SHALL drop independently after its own handshake. The FSM SHALL move to WR_RESP in the cycle both handshakes have completed, including the case where both complete in the same cycle.
REQ-008 SHALL drive b_ready_o=1 throughout WR_RESP. On b_valid_i it SHALL latch resp and move to DONE.
REQ-009 SHALL assert rw_ready_o (registered) only in DONE, for exactly one cycle. DONE SHALL always return to IDLE, so a new request is accepted no earlier than 2 cycles after the previous pulse.
REQ-010 SHALL accept no new request outside IDLE. Changes on rw_* inputs while a transaction is in flight SHALL be ignored.
REQ-011 SHALL drive these constant AXI fields: aw/ar_len=0, aw/ar_burst=2'b01, w_last_o=1.
REQ-012 SHALL set aw/ar_size equal to the clamped size and aw/ar_addr equal to the captured addr[31:0], unaligned.
REQ-013 SHALL compute the write lane alignment from off = addr[2:0]:
- w_data_o = wdata << (8*off), truncated to 64 bits
- w_strb_o = ({1,3,15,255}[size] << off) & 8'hFF
REQ-014 SHALL set rw_rdata_o = r_data >> (8*off), zero-filled. Sign and zero extension are not this block's job.
REQ-015 SHALL hold rw_rdata_o until the next read completes. Writes SHALL NOT modify it.
REQ-016 SHALL assert rw_err_o together with rw_ready_o when the latched resp != 2'b00. The transaction SHALL still complete normally.
REQ-017 SHALL keep all AXI outputs stable while their valid is high and unhandshaked (AXI stability rule).
REQ-018 Minimum latency with zero-wait slaves SHALL be:
- read: 4 cycles from rw_cen_i to rw_ready_o (IDLE, RD_ADDR, RD_DATA, DONE)
- write: 4 cycles (IDLE, WR_REQ, WR_RESP, DONE)

Reset
REQ-019 SHALL apply the following on rst_n=0 at a clock edge:
- FSM returns to IDLE
- all valid/ready outputs, rw_ready_o and rw_err_o = 0
- rw_rdata_o and all address/data/strb outputs = 0
REQ-020 Reset mid-transaction SHALL abandon the transaction immediately, without waiting for outstanding handshakes. No rw_ready_o pulse SHALL follow for the abandoned request.

Verification
REQ-021 Read, addr=0x8000_0004, size=2, zero-wait slave, r_data=0x1122_3344_5566_7788 -> ar_addr=0x8000_0004, ar_size=2; rw_ready_o pulses once 4 cycles after request; rw_rdata_o=0x0000_0000_1122_3344.
REQ-022 Write, addr=0x8000_0003, size=0, wdata=0xAB -> w_strb=8'h08, w_data=0x0000_0000_AB00_0000; aw_valid and w_valid asserted together; ready pulse one cycle after B handshake.
REQ-023 Write with aw_ready delayed 3 cycles and w_ready immediate -> w_valid drops after 1 cycle, aw_valid holds 3 cycles with stable addr, WR_RESP entered only after AW handshake.
REQ-024 Read with r_resp=2'b10 and r_valid delayed 5 cycles -> r_ready held high throughout; rw_ready_o and rw_err_o pulse together; FSM returns to IDLE.
REQ-025 rst_n=0 for one cycle during RD_DATA, then a new write request -> all outputs 0 after the reset edge; no ready pulse for the aborted read; the write completes normally.
REQ-026 rw_cen_i held high across the ready pulse -> second transaction starts from IDLE 2 cycles after the pulse, never overlapping the first.
